load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DW, default 32, data word width (matches `WORD).
REQ-002 SHALL have parameter IW, default `INDEX_MSB, memory word-index width; memory depth 2**IW words.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have core-side ports req_i in 1 (request valid), ready_o out 1 (request accepted when req_i&ready_o), we_i in 1 (1=store, 0=load), addr_i in DW (byte address), size_i in 2 (00 byte, 01 half, 10 word, 11 illegal), unsigned_i in 1 (zero-extend loads), wdata_i in DW (store data, LSB-aligned).
REQ-006 SHALL have core-side response ports rsp_valid_o out 1 (one-cycle pulse), rdata_o out DW (load result), err_o out 1 (access faulted, qualified by rsp_valid_o).
REQ-007 SHALL have memory-side ports WE_o out 1, RE_o out 1, Addr_o out IW (word index), DataW_o out DW, DataR_i in DW (data valid the cycle after RE_o).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, LD_DATA, RMW_MERGE, RESP; ready_o=1 only in IDLE with rst_ni high.
REQ-009 SHALL latch we_i, addr_i, size_i, unsigned_i, wdata_i on the accepting edge.
REQ-010 SHALL fault when: size_i=11; half at odd address; word with addr_i[1:0]!=0; any addr_i bit above IW+1 set. Fault: IDLE->RESP, err_o=1, rdata_o=0, no RE_o/WE_o.
REQ-011 SHALL, for a legal request, go IDLE->ACCESS; Addr_o=addr[IW+1:2] registered, held until return to IDLE.
REQ-012 Load: ACCESS drives RE_o=1 one cycle -> LD_DATA selects byte lane addr[1:0] / half lane addr[1], little-endian, sign- or zero-extends per unsigned_i, registers into rdata_o -> RESP.
REQ-013 Word store: ACCESS drives WE_o=1, DataW_o=wdata one cycle -> RESP.
REQ-014 Byte/half store: ACCESS drives RE_o=1 -> RMW_MERGE drives WE_o=1 one cycle with DataW_o = DataR_i with the addressed lane replaced by wdata low bits -> RESP.
REQ-015 RESP: rsp_valid_o=1 for exactly one cycle -> IDLE; rdata_o holds until next load response; err_o=0 on legal accesses.
REQ-016 Latency from accepting edge to rsp_valid_o high: load 3 cycles, word store 2, sub-word store 3, fault 1.
REQ-017 WE_o and RE_o SHALL never both be 1; each high at most one cycle per request; both 0 in IDLE and RESP.
REQ-018 Requests during non-IDLE states SHALL be ignored (ready_o=0); back-to-back accepted only from IDLE, giving one idle-accept cycle between responses.

Reset
REQ-019 rst_ni low SHALL asynchronously force state IDLE and ready_o, rsp_valid_o, err_o, WE_o, RE_o to 0, Addr_o, DataW_o, rdata_o to 0.
REQ-020 Reset mid-operation SHALL abandon the request without response; a write not yet clocked into memory SHALL not occur.
REQ-021 After rst_ni rises, ready_o SHALL be 1 in the first cycle.

Structure
REQ-022 DW, IW, `WORD and size encodings SHALL come from the shared include lagartoII_const.vh; FSM state encodings local.
REQ-023 Lane extraction/extension and lane merge SHALL live in one combinational sub-module lsu_lane_align, instantiated once.

Verification
REQ-024 Memory word 4 = 0x87654321; load byte signed @0x11 -> rdata_o 0x00000043; @0x13 -> 0xFFFFFF87; @0x13 unsigned -> 0x00000087; response 3 cycles after accept.
REQ-025 Store half 0xBEEF @0x12 into word 4 = 0x87654321 -> one RE_o, then one WE_o with DataW_o 0xBEEF4321; rsp_valid_o 3 cycles after accept.
REQ-026 Store word 0xDEADBEEF @0x20 -> WE_o once, Addr_o 8, rsp 2 cycles after accept; load word @0x20 returns 0xDEADBEEF.
REQ-027 Load word @0x13, half @0x11, size 11, out-of-range address -> err_o=1 with rsp_valid_o 1 cycle after accept, RE_o/WE_o never asserted.
REQ-028 rst_ni low during RMW_MERGE -> WE_o drops immediately, no rsp_valid_o, target word unchanged, ready_o=1 first cycle after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: word geometry, access-size
// encodings and the alignment rule applied to incoming requests.
package load_store_unit_pkg;

  localparam int unsigned WORD    = 32;
  localparam int unsigned INDEX_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // True when the size code is illegal or the byte offset breaks natural alignment.
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational little-endian lane handling: load extraction with sign/zero
// extension, and sub-word lane merge for read-modify-write stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DW = WORD
) (
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [1:0]    off_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  output logic [DW-1:0] ld_data_o,
  output logic [DW-1:0] st_data_o
);

  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [DW-1:0] mask;
  logic [DW-1:0] wshift;

  always_comb begin
    byte_v    = 8'(rdata_i >> {off_i, 3'b000});
    half_v    = 16'(rdata_i >> {off_i[1], 4'b0000});
    ld_data_o = rdata_i;
    mask      = '1;
    wshift    = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{(DW-8){~unsigned_i & byte_v[7]}}, byte_v};
        mask      = DW'(8'hFF) << {off_i, 3'b000};
        wshift    = wdata_i << {off_i, 3'b000};
      end
      SZ_HALF: begin
        ld_data_o = {{(DW-16){~unsigned_i & half_v[15]}}, half_v};
        mask      = DW'(16'hFFFF) << {off_i[1], 4'b0000};
        wshift    = wdata_i << {off_i[1], 4'b0000};
      end
      default: ;
    endcase
    st_data_o = (rdata_i & ~mask) | (wshift & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a core request port to a
// word-addressed synchronous memory; sub-word stores use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DW = WORD,
  parameter int unsigned IW = INDEX_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  output logic          ready_o,
  input  logic          we_i,
  input  logic [DW-1:0] addr_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [DW-1:0] wdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          WE_o,
  output logic          RE_o,
  output logic [IW-1:0] Addr_o,
  output logic [DW-1:0] DataW_o,
  input  logic [DW-1:0] DataR_i
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ACCESS    = 3'd1;
  localparam logic [2:0] LD_DATA   = 3'd2;
  localparam logic [2:0] RMW_MERGE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  logic [2:0]    state_q;
  logic          we_q, uns_q, err_q;
  logic [1:0]    off_q, size_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [IW-1:0] addr_q;
  logic          accept, fault, word_store;
  logic [DW-1:0] ld_data, st_data;

  assign accept     = req_i && (state_q == IDLE);
  assign fault      = bad_size_align(size_i, addr_i[1:0]) || ((addr_i >> (IW + 2)) != '0);
  assign word_store = we_q && (size_q == SZ_WORD);

  lsu_lane_align #(.DW(DW)) u_align (
    .rdata_i    (DataR_i),
    .wdata_i    (wdata_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ld_data_o  (ld_data),
    .st_data_o  (st_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= we_i;
          uns_q   <= unsigned_i;
          off_q   <= addr_i[1:0];
          size_q  <= size_i;
          wdata_q <= wdata_i;
          addr_q  <= addr_i[IW+1:2];
          err_q   <= fault;
          if (fault) rdata_q <= '0;
          state_q <= fault ? RESP : ACCESS;
        end
        ACCESS:    state_q <= word_store ? RESP : (we_q ? RMW_MERGE : LD_DATA);
        LD_DATA: begin
          rdata_q <= ld_data;
          state_q <= RESP;
        end
        RMW_MERGE: state_q <= RESP;
        RESP:      state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    RE_o    = (state_q == ACCESS) && !word_store;
    WE_o    = ((state_q == ACCESS) && word_store) || (state_q == RMW_MERGE);
    DataW_o = '0;
    if (state_q == ACCESS && word_store) DataW_o = wdata_q;
    else if (state_q == RMW_MERGE)       DataW_o = st_data;
  end

  assign ready_o     = (state_q == IDLE) && rst_ni;
  assign rsp_valid_o = (state_q == RESP);
  assign err_o       = (state_q == RESP) && err_q;
  assign rdata_o     = rdata_q;
  assign Addr_o      = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous memory.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, unsigned_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        ready_o, rsp_valid_o, err_o, WE_o, RE_o;
  logic [31:0] rdata_o, DataW_o, DataR_i;
  logic [7:0]  Addr_o;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int total = 0;
  int bad   = 0;
  int both  = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.DW(32), .IW(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ready_o(ready_o),
    .we_i(we_i), .addr_i(addr_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .wdata_i(wdata_i), .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o),
    .err_o(err_o), .WE_o(WE_o), .RE_o(RE_o), .Addr_o(Addr_o),
    .DataW_o(DataW_o), .DataR_i(DataR_i)
  );

  always @(posedge clk_i) begin
    if (RE_o) DataR_i <= mem[Addr_o];
    if (WE_o) mem[Addr_o] <= DataW_o;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd_in,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int nre, output int nwe, output logic [31:0] wdat,
                     output logic [7:0] wadr, output logic rdy);
    lat = -1; rd = 'x; er = 1'bx; nre = 0; nwe = 0; wdat = '0; wadr = '0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = sz; unsigned_i = uns; wdata_i = wd_in;
    rdy = ready_o;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      if (RE_o) nre++;
      if (WE_o) begin nwe++; wdat = DataW_o; wadr = Addr_o; end
      if (RE_o && WE_o) both++;
      if (rsp_valid_o) begin lat = c; rd = rdata_o; er = err_o; break; end
    end
  endtask

  int lat, nre, nwe;
  logic [31:0] rd, wdat;
  logic [7:0] wadr;
  logic er, rdy;

  task automatic test_reset;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; size_i = '0;
    unsigned_i = 1'b0; wdata_i = '0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({ready_o, rsp_valid_o, err_o, WE_o, RE_o} !== 5'b0 || Addr_o !== 8'h0 ||
        DataW_o !== 32'h0 || rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rsp=%b err=%b we=%b re=%b addr=%h dw=%h rd=%h, want all zero",
               ready_o, rsp_valid_o, err_o, WE_o, RE_o, Addr_o, DataW_o, rdata_o);
    end
    rst_ni = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_load_byte;
    preload(8'd4, 32'h87654321);
    run(1'b0, 32'h11, 2'b00, 1'b0, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (rdy !== 1'b1 || lat !== 3 || rd !== 32'h00000043 || er !== 1'b0 || nre !== 1 || nwe !== 0) begin
      bad++;
      $display("FAIL ldb_s_0x11: got rdy=%b lat=%0d rd=%h err=%b re=%0d we=%0d want 1 3 00000043 0 1 0",
               rdy, lat, rd, er, nre, nwe);
    end
    run(1'b0, 32'h13, 2'b00, 1'b0, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || rd !== 32'hFFFFFF87 || er !== 1'b0) begin
      bad++; $display("FAIL ldb_s_0x13: got lat=%0d rd=%h err=%b want 3 ffffff87 0", lat, rd, er);
    end
    run(1'b0, 32'h13, 2'b00, 1'b1, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || rd !== 32'h00000087) begin
      bad++; $display("FAIL ldb_u_0x13: got lat=%0d rd=%h want 3 00000087", lat, rd);
    end
  endtask

  task automatic test_store_half;
    run(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000BEEF, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || nre !== 1 || nwe !== 1 || wdat !== 32'hBEEF4321 || wadr !== 8'd4 || er !== 1'b0) begin
      bad++;
      $display("FAIL sth_0x12: got lat=%0d re=%0d we=%0d dw=%h addr=%0d err=%b want 3 1 1 beef4321 4 0",
               lat, nre, nwe, wdat, wadr, er);
    end
    total++;
    if (mem[4] !== 32'hBEEF4321) begin bad++; $display("FAIL sth_mem: got %h want beef4321", mem[4]); end
    run(1'b0, 32'h12, 2'b01, 1'b0, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || rd !== 32'hFFFFBEEF) begin
      bad++; $display("FAIL ldh_s_0x12: got lat=%0d rd=%h want 3 ffffbeef", lat, rd);
    end
  endtask

  task automatic test_store_word;
    run(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 2 || nre !== 0 || nwe !== 1 || wdat !== 32'hDEADBEEF || wadr !== 8'd8 || er !== 1'b0) begin
      bad++;
      $display("FAIL stw_0x20: got lat=%0d re=%0d we=%0d dw=%h addr=%0d err=%b want 2 0 1 deadbeef 8 0",
               lat, nre, nwe, wdat, wadr, er);
    end
    run(1'b0, 32'h20, 2'b10, 1'b0, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ldw_0x20: got lat=%0d rd=%h want 3 deadbeef", lat, rd);
    end
    run(1'b1, 32'h21, 2'b00, 1'b0, 32'h123456AA, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || wdat !== 32'hDEADAAEF) begin
      bad++; $display("FAIL stb_0x21: got lat=%0d dw=%h want 3 deadaaef", lat, wdat);
    end
    run(1'b0, 32'h21, 2'b00, 1'b1, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (rd !== 32'h000000AA) begin bad++; $display("FAIL ldb_u_0x21: got %h want 000000aa", rd); end
    preload(8'd255, 32'h0BADF00D);
    run(1'b0, 32'h3FC, 2'b10, 1'b0, '0, lat, rd, er, nre, nwe, wdat, wadr, rdy);
    total++;
    if (lat !== 3 || rd !== 32'h0BADF00D || er !== 1'b0) begin
      bad++; $display("FAIL ldw_top: got lat=%0d rd=%h err=%b want 3 0badf00d 0", lat, rd, er);
    end
  endtask

  task automatic test_faults;
    logic [31:0] fa [4];
    logic [1:0]  fs [4];
    fa[0] = 32'h13;  fs[0] = 2'b10;
    fa[1] = 32'h11;  fs[1] = 2'b01;
    fa[2] = 32'h10;  fs[2] = 2'b11;
    fa[3] = 32'h400; fs[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      run(i[0], fa[i], fs[i], 1'b0, 32'hFFFFFFFF, lat, rd, er, nre, nwe, wdat, wadr, rdy);
      total++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nre !== 0 || nwe !== 0) begin
        bad++;
        $display("FAIL fault_%0d: got lat=%0d err=%b rd=%h re=%0d we=%0d want 1 1 00000000 0 0",
                 i, lat, er, rd, nre, nwe);
      end
    end
    total++;
    if (mem[4] !== 32'hBEEF4321) begin bad++; $display("FAIL fault_mem: got %h want beef4321", mem[4]); end
  endtask

  task automatic test_back_to_back;
    int rsp_at [$];
    int n_ready, n_re;
    n_ready = 0; n_re = 0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20; size_i = 2'b10; unsigned_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (c == 8) req_i = 1'b0;
      if (c < 8 && ready_o) n_ready++;
      if (RE_o) n_re++;
      if (rsp_valid_o) rsp_at.push_back(c);
    end
    total++;
    if (rsp_at.size() != 2 || rsp_at[0] != 3 || rsp_at[1] != 7 || n_ready != 1 || n_re != 2) begin
      bad++;
      $display("FAIL back_to_back: got rsps=%0d first=%0d second=%0d ready=%0d re=%0d want 2 3 7 1 2",
               rsp_at.size(), rsp_at.size() > 0 ? rsp_at[0] : -1,
               rsp_at.size() > 1 ? rsp_at[1] : -1, n_ready, n_re);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_rmw;
    logic we_before, we_after, saw_rsp;
    saw_rsp = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h12; size_i = 2'b01; wdata_i = 32'h1234;
    @(negedge clk_i);
    req_i = 1'b0;
    @(posedge clk_i);
    #1 we_before = WE_o;
    rst_ni = 1'b0;
    #1 we_after = WE_o;
    repeat (2) begin
      @(negedge clk_i);
      if (rsp_valid_o) saw_rsp = 1'b1;
    end
    rst_ni = 1'b1;
    #1;
    total++;
    if (we_before !== 1'b1 || we_after !== 1'b0 || saw_rsp !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_rmw: got we_pre=%b we_post=%b rsp=%b ready=%b want 1 0 0 1",
               we_before, we_after, saw_rsp, ready_o);
    end
    @(negedge clk_i);
    total++;
    if (mem[4] !== 32'hBEEF4321) begin bad++; $display("FAIL reset_rmw_mem: got %h want beef4321", mem[4]); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_store_word();
    test_faults();
    test_back_to_back();
    test_reset_mid_rmw();
    total++;
    if (both !== 0) begin bad++; $display("FAIL we_re_overlap: got %0d cycles want 0", both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
